rv32_execute: RTL and testbench
===============================

Name: rv32_execute

Overview:
- Execute stage of the rv32 five-stage pipeline. Sits between decode and the memory stage.
- Computes the ALU result, the branch target and the store data, then registers them together with the memory, branch and writeback controls for the memory stage.
- Contains an iterative RV32M multiply/divide unit. It stalls upstream for the duration of each M-extension operation.

Parameters:
- MULDIV_CYCLES, 32, iteration count of the multiply/divide unit; fixed at 32 for RV32.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- valid_in  in  1  decode presents a valid instruction
- flush_in  in  1  branch taken in the memory stage; kill the current instruction
- alu_op_in  in  4  ALU operation (package constants)
- alu_src1_pc_in  in  1  operand 1 = pc_in (else rs1_value_in)
- alu_src2_imm_in  in  1  operand 2 = imm_value_in (else rs2_value_in)
- muldiv_en_in  in  1  instruction is RV32M
- muldiv_op_in  in  3  MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
- jalr_in  in  1  branch target base = rs1 (else pc)
- pc_in, rs1_value_in, rs2_value_in, imm_value_in  in  32 each  operands
- read_en_in, write_en_in  in  1 each  memory controls
- width_in  in  2  memory width
- zero_extend_in  in  1  memory load extension select
- branch_op_in  in  2  branch condition
- rd_in  in  5  destination register
- rd_writeback_in  in  1  writeback enable
- stall_out  out  1  upstream must hold all inputs
- read_en_out, write_en_out, width_out, zero_extend_out, branch_op_out, rd_out, rd_writeback_out  out  as inputs  registered controls
- result_out  out  32  ALU/muldiv result; memory address for loads and stores
- rs2_value_out  out  32  store data
- branch_pc_out  out  32  branch target

Behaviour:
- All outputs are registered on posedge clk except stall_out, which is combinational.
- Reset: every registered output is 0, so branch_op_out = never-taken. FSM goes to IDLE.
- Bubble: when valid_in=0, flush_in=1 or stall_out=1, the next output is read_en/write_en/rd_writeback = 0 and branch_op = never-taken. The data fields are don't-care.
- ALU ops:
  - ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS2 (LUI).
  - Shifts use operand2[4:0].
  - Branch compares use SUB/SLT/SLTU; the memory stage evaluates result_out.
- Branch target: (jalr_in ? rs1_value_in : pc_in) + imm_value_in. When jalr_in=1, bit 0 is cleared.
- Non-muldiv instruction: latency 1, throughput 1 per cycle, stall_out=0.
- Muldiv FSM, states IDLE -> BUSY -> DONE -> IDLE:
  - IDLE, with valid_in & muldiv_en_in & !flush_in: stall_out=1; operands and op are latched; count=0; next state BUSY.
  - BUSY: stall_out=1. One iteration per cycle: shift-add for multiply, restoring division for divide. After the count==MULDIV_CYCLES-1 cycle, next state DONE.
  - DONE: stall_out=0. The output register captures the muldiv result plus the held controls, then returns to IDLE.
  - Timing: stall_out is high for 33 consecutive cycles and the result appears 34 cycles after acceptance.
- Signedness:
  - Operands are converted to magnitudes before iteration; the sign is fixed up in DONE.
  - MULHSU treats rs1 as signed and rs2 as unsigned.
  - MUL returns the low 32 bits; MULH* return the high 32 bits.
- Divide corner cases (still take the full cycle count):
  - Divisor 0: quotient = 0xFFFFFFFF, remainder = dividend.
  - DIV/REM with 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
  - Remainder sign follows the dividend.
- Flush has priority over everything. flush_in in any state forces IDLE and makes the next output a bubble. stall_out falls in the same cycle because it is combinational from flush_in.
- Asynchronous reset mid-operation aborts to IDLE with the reset outputs above.

Decomposition:
- Shared package rv32_execute_ops holds:
  - ALU op constants RV32_ALU_OP_*.
  - Muldiv op constants RV32_MULDIV_OP_*.
  - The FSM state enum.
- Memory width and branch op constants stay in the existing memory-ops and branch packages.
- One sub-module, rv32_muldiv:
  - Holds the FSM, iteration datapath and sign/corner handling.
  - Interface: start, op, a, b, flush, busy, done, result.
- The ALU stays inline.

Test Plan:
- ADD: rs1=5, rs2=0xFFFFFFFD, alu ADD -> next cycle result_out=2, stall_out=0; controls pass through unchanged.
- Store: write_en=1, width=BYTE, rs1=0x100, imm=3, rs2=0xAB -> result_out=0x103, rs2_value_out=0xAB, write_en_out=1.
- MUL: 7 × 0xFFFFFFFD -> stall_out high exactly 33 cycles with bubbles output; then result_out=0xFFFFFFEB, rd_writeback_out=1 for one cycle.
- DIVU by zero: 10/0 -> 0xFFFFFFFF. REM with 0x80000000 % 0xFFFFFFFF -> 0. MULH with 0x80000000 × 0x80000000 -> 0x40000000.
- Flush mid-divide: flush_in at iteration 10 -> stall_out=0 that cycle, next output is a bubble; a new ADD is accepted the following cycle.
- Reset: reset asserted during BUSY -> all outputs 0 immediately (async), FSM IDLE; JALR with rs1=0x1001, imm=4 after release -> branch_pc_out=0x1004.

Source files
------------

// File: rtl/rv32_execute_ops.sv
// Shared encodings for the rv32 execute stage: ALU ops, M-extension ops
// and the multiply/divide sequencer states.
package rv32_execute_ops;

    localparam logic [3:0] RV32_ALU_OP_ADD   = 4'd0;
    localparam logic [3:0] RV32_ALU_OP_SUB   = 4'd1;
    localparam logic [3:0] RV32_ALU_OP_SLL   = 4'd2;
    localparam logic [3:0] RV32_ALU_OP_SLT   = 4'd3;
    localparam logic [3:0] RV32_ALU_OP_SLTU  = 4'd4;
    localparam logic [3:0] RV32_ALU_OP_XOR   = 4'd5;
    localparam logic [3:0] RV32_ALU_OP_SRL   = 4'd6;
    localparam logic [3:0] RV32_ALU_OP_SRA   = 4'd7;
    localparam logic [3:0] RV32_ALU_OP_OR    = 4'd8;
    localparam logic [3:0] RV32_ALU_OP_AND   = 4'd9;
    localparam logic [3:0] RV32_ALU_OP_PASS2 = 4'd10;

    // Same numbering as funct3 of the OP/M instructions.
    localparam logic [2:0] RV32_MULDIV_OP_MUL    = 3'd0;
    localparam logic [2:0] RV32_MULDIV_OP_MULH   = 3'd1;
    localparam logic [2:0] RV32_MULDIV_OP_MULHSU = 3'd2;
    localparam logic [2:0] RV32_MULDIV_OP_MULHU  = 3'd3;
    localparam logic [2:0] RV32_MULDIV_OP_DIV    = 3'd4;
    localparam logic [2:0] RV32_MULDIV_OP_DIVU   = 3'd5;
    localparam logic [2:0] RV32_MULDIV_OP_REM    = 3'd6;
    localparam logic [2:0] RV32_MULDIV_OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } muldiv_state_t;

    function automatic logic muldiv_a_signed(input logic [2:0] op);
        return (op == RV32_MULDIV_OP_MULH) || (op == RV32_MULDIV_OP_MULHSU) ||
               (op == RV32_MULDIV_OP_DIV)  || (op == RV32_MULDIV_OP_REM);
    endfunction

    function automatic logic muldiv_b_signed(input logic [2:0] op);
        return (op == RV32_MULDIV_OP_MULH) || (op == RV32_MULDIV_OP_DIV) ||
               (op == RV32_MULDIV_OP_REM);
    endfunction

endpackage

// File: rtl/rv32_muldiv.sv
// Iterative RV32M unit: one shift-add or restoring-divide step per cycle on
// operand magnitudes, with the sign and divide-by-zero fix-up applied in DONE.
module rv32_muldiv
    import rv32_execute_ops::*;
#(
    parameter int MULDIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o
);

    localparam logic [4:0] LAST_COUNT = 5'(MULDIV_CYCLES - 1);

    muldiv_state_t state_q;
    logic [4:0]    count_q;
    logic [2:0]    op_q;
    logic [31:0]   hi_q;
    logic [31:0]   lo_q;
    logic [31:0]   b_q;
    logic          neg_a_q;
    logic          neg_b_q;
    logic          b_zero_q;

    logic          neg_a_d;
    logic          neg_b_d;
    logic [31:0]   mag_a_d;
    logic [31:0]   mag_b_d;

    logic [32:0]   mul_sum;
    logic [32:0]   div_shift;
    logic          div_fits;
    logic [31:0]   div_sub;
    logic [31:0]   hi_d;
    logic [31:0]   lo_d;

    logic [63:0]   product;
    logic [63:0]   product_fixed;
    logic [31:0]   quotient;
    logic [31:0]   remainder;

    always_comb begin
        neg_a_d = muldiv_a_signed(op_i) & a_i[31];
        neg_b_d = muldiv_b_signed(op_i) & b_i[31];
        mag_a_d = neg_a_d ? (~a_i + 32'd1) : a_i;
        mag_b_d = neg_b_d ? (~b_i + 32'd1) : b_i;
    end

    // hi/lo double as {accumulator, multiplier} or {partial remainder, quotient}.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : 33'd0);
        div_shift = {hi_q, lo_q[31]};
        div_fits  = div_shift >= {1'b0, b_q};
        div_sub   = div_shift[31:0] - b_q;
        if (op_q[2]) begin
            hi_d = div_fits ? div_sub : div_shift[31:0];
            lo_d = {lo_q[30:0], div_fits};
        end else begin
            hi_d = mul_sum[32:1];
            lo_d = {mul_sum[0], lo_q[31:1]};
        end
    end

    always_comb begin
        product       = {hi_q, lo_q};
        product_fixed = (neg_a_q ^ neg_b_q) ? (~product + 64'd1) : product;
        if (b_zero_q) begin
            quotient = 32'hFFFF_FFFF;
        end else begin
            quotient = (neg_a_q ^ neg_b_q) ? (~lo_q + 32'd1) : lo_q;
        end
        // Remainder sign follows the dividend; also yields rem = dividend for b == 0.
        remainder = neg_a_q ? (~hi_q + 32'd1) : hi_q;
        case (op_q)
            RV32_MULDIV_OP_MUL:                   result_o = product_fixed[31:0];
            RV32_MULDIV_OP_DIV, RV32_MULDIV_OP_DIVU: result_o = quotient;
            RV32_MULDIV_OP_REM, RV32_MULDIV_OP_REMU: result_o = remainder;
            default:                              result_o = product_fixed[63:32];
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= MD_IDLE;
            count_q  <= 5'd0;
            op_q     <= 3'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            b_q      <= 32'd0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            b_zero_q <= 1'b0;
        end else if (flush_i) begin
            state_q <= MD_IDLE;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (start_i) begin
                        op_q     <= op_i;
                        hi_q     <= 32'd0;
                        lo_q     <= mag_a_d;
                        b_q      <= mag_b_d;
                        neg_a_q  <= neg_a_d;
                        neg_b_q  <= neg_b_d;
                        b_zero_q <= (b_i == 32'd0);
                        count_q  <= 5'd0;
                        state_q  <= MD_BUSY;
                    end
                end
                MD_BUSY: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    count_q <= count_q + 5'd1;
                    if (count_q == LAST_COUNT) begin
                        state_q <= MD_DONE;
                    end
                end
                default: begin
                    state_q <= MD_IDLE;
                end
            endcase
        end
    end

    assign busy_o = (state_q == MD_BUSY);
    assign done_o = (state_q == MD_DONE);

endmodule

// File: rtl/rv32_execute.sv
// rv32 execute stage: inline ALU and branch-target adder plus the iterative
// M-extension unit, registered together with the controls for the memory stage.
module rv32_execute
    import rv32_execute_ops::*;
#(
    parameter int MULDIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic        flush_in,
    input  logic [3:0]  alu_op_in,
    input  logic        alu_src1_pc_in,
    input  logic        alu_src2_imm_in,
    input  logic        muldiv_en_in,
    input  logic [2:0]  muldiv_op_in,
    input  logic        jalr_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] rs1_value_in,
    input  logic [31:0] rs2_value_in,
    input  logic [31:0] imm_value_in,
    input  logic        read_en_in,
    input  logic        write_en_in,
    input  logic [1:0]  width_in,
    input  logic        zero_extend_in,
    input  logic [1:0]  branch_op_in,
    input  logic [4:0]  rd_in,
    input  logic        rd_writeback_in,
    output logic        stall_out,
    output logic        read_en_out,
    output logic        write_en_out,
    output logic [1:0]  width_out,
    output logic        zero_extend_out,
    output logic [1:0]  branch_op_out,
    output logic [4:0]  rd_out,
    output logic        rd_writeback_out,
    output logic [31:0] result_out,
    output logic [31:0] rs2_value_out,
    output logic [31:0] branch_pc_out
);

    // Never-taken encoding of the branch unit; also the reset value.
    localparam logic [1:0] BRANCH_OP_NEVER = 2'b00;

    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  shamt;
    logic [31:0] alu_result;
    logic [31:0] branch_base;
    logic [31:0] branch_sum;

    logic        md_busy;
    logic        md_done;
    logic        md_start;
    logic [31:0] md_result;
    logic        accept;

    logic [31:0] result_d;
    logic [31:0] branch_pc_d;

    assign op1   = alu_src1_pc_in  ? pc_in        : rs1_value_in;
    assign op2   = alu_src2_imm_in ? imm_value_in : rs2_value_in;
    assign shamt = op2[4:0];

    always_comb begin
        case (alu_op_in)
            RV32_ALU_OP_ADD:   alu_result = op1 + op2;
            RV32_ALU_OP_SUB:   alu_result = op1 - op2;
            RV32_ALU_OP_SLL:   alu_result = op1 << shamt;
            RV32_ALU_OP_SLT:   alu_result = {31'd0, $signed(op1) < $signed(op2)};
            RV32_ALU_OP_SLTU:  alu_result = {31'd0, op1 < op2};
            RV32_ALU_OP_XOR:   alu_result = op1 ^ op2;
            RV32_ALU_OP_SRL:   alu_result = op1 >> shamt;
            RV32_ALU_OP_SRA:   alu_result = 32'($signed(op1) >>> shamt);
            RV32_ALU_OP_OR:    alu_result = op1 | op2;
            RV32_ALU_OP_AND:   alu_result = op1 & op2;
            RV32_ALU_OP_PASS2: alu_result = op2;
            default:           alu_result = 32'd0;
        endcase
    end

    assign branch_base = jalr_in ? rs1_value_in : pc_in;
    assign branch_sum  = branch_base + imm_value_in;
    assign branch_pc_d = {branch_sum[31:1], branch_sum[0] & ~jalr_in};

    rv32_muldiv #(
        .MULDIV_CYCLES (MULDIV_CYCLES)
    ) u_muldiv (
        .clk      (clk),
        .reset    (reset),
        .start_i  (md_start),
        .op_i     (muldiv_op_in),
        .a_i      (rs1_value_in),
        .b_i      (rs2_value_in),
        .flush_i  (flush_in),
        .busy_o   (md_busy),
        .done_o   (md_done),
        .result_o (md_result)
    );

    // In DONE the stalled instruction is still on the inputs, so its controls
    // are captured straight from the ports alongside the muldiv result.
    assign md_start  = valid_in & muldiv_en_in & ~flush_in & ~md_busy & ~md_done;
    assign stall_out = md_start | (md_busy & ~flush_in);
    assign accept    = valid_in & ~flush_in & ~stall_out;
    assign result_d  = (muldiv_en_in & md_done) ? md_result : alu_result;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_en_out      <= 1'b0;
            write_en_out     <= 1'b0;
            width_out        <= 2'd0;
            zero_extend_out  <= 1'b0;
            branch_op_out    <= BRANCH_OP_NEVER;
            rd_out           <= 5'd0;
            rd_writeback_out <= 1'b0;
            result_out       <= 32'd0;
            rs2_value_out    <= 32'd0;
            branch_pc_out    <= 32'd0;
        end else begin
            read_en_out      <= accept & read_en_in;
            write_en_out     <= accept & write_en_in;
            rd_writeback_out <= accept & rd_writeback_in;
            branch_op_out    <= accept ? branch_op_in : BRANCH_OP_NEVER;
            width_out        <= width_in;
            zero_extend_out  <= zero_extend_in;
            rd_out           <= rd_in;
            result_out       <= result_d;
            rs2_value_out    <= rs2_value_in;
            branch_pc_out    <= branch_pc_d;
        end
    end

endmodule

// File: tb/tb_rv32_execute.sv
// Directed bench for rv32_execute: ALU, stores, branch targets, RV32M ops and
// their corner cases, flush mid-divide and asynchronous reset mid-multiply.
module tb_rv32_execute;
    import rv32_execute_ops::*;

    logic        clk;
    logic        reset;
    logic        valid_in;
    logic        flush_in;
    logic [3:0]  alu_op_in;
    logic        alu_src1_pc_in;
    logic        alu_src2_imm_in;
    logic        muldiv_en_in;
    logic [2:0]  muldiv_op_in;
    logic        jalr_in;
    logic [31:0] pc_in;
    logic [31:0] rs1_value_in;
    logic [31:0] rs2_value_in;
    logic [31:0] imm_value_in;
    logic        read_en_in;
    logic        write_en_in;
    logic [1:0]  width_in;
    logic        zero_extend_in;
    logic [1:0]  branch_op_in;
    logic [4:0]  rd_in;
    logic        rd_writeback_in;
    logic        stall_out;
    logic        read_en_out;
    logic        write_en_out;
    logic [1:0]  width_out;
    logic        zero_extend_out;
    logic [1:0]  branch_op_out;
    logic [4:0]  rd_out;
    logic        rd_writeback_out;
    logic [31:0] result_out;
    logic [31:0] rs2_value_out;
    logic [31:0] branch_pc_out;

    int checks = 0;
    int errors = 0;

    rv32_execute #(.MULDIV_CYCLES(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .valid_in         (valid_in),
        .flush_in         (flush_in),
        .alu_op_in        (alu_op_in),
        .alu_src1_pc_in   (alu_src1_pc_in),
        .alu_src2_imm_in  (alu_src2_imm_in),
        .muldiv_en_in     (muldiv_en_in),
        .muldiv_op_in     (muldiv_op_in),
        .jalr_in          (jalr_in),
        .pc_in            (pc_in),
        .rs1_value_in     (rs1_value_in),
        .rs2_value_in     (rs2_value_in),
        .imm_value_in     (imm_value_in),
        .read_en_in       (read_en_in),
        .write_en_in      (write_en_in),
        .width_in         (width_in),
        .zero_extend_in   (zero_extend_in),
        .branch_op_in     (branch_op_in),
        .rd_in            (rd_in),
        .rd_writeback_in  (rd_writeback_in),
        .stall_out        (stall_out),
        .read_en_out      (read_en_out),
        .write_en_out     (write_en_out),
        .width_out        (width_out),
        .zero_extend_out  (zero_extend_out),
        .branch_op_out    (branch_op_out),
        .rd_out           (rd_out),
        .rd_writeback_out (rd_writeback_out),
        .result_out       (result_out),
        .rs2_value_out    (rs2_value_out),
        .branch_pc_out    (branch_pc_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_in        = 1'b0;
        flush_in        = 1'b0;
        alu_op_in       = RV32_ALU_OP_ADD;
        alu_src1_pc_in  = 1'b0;
        alu_src2_imm_in = 1'b0;
        muldiv_en_in    = 1'b0;
        muldiv_op_in    = 3'd0;
        jalr_in         = 1'b0;
        pc_in           = 32'd0;
        rs1_value_in    = 32'd0;
        rs2_value_in    = 32'd0;
        imm_value_in    = 32'd0;
        read_en_in      = 1'b0;
        write_en_in     = 1'b0;
        width_in        = 2'd0;
        zero_extend_in  = 1'b0;
        branch_op_in    = 2'd0;
        rd_in           = 5'd0;
        rd_writeback_in = 1'b0;
    endtask

    task automatic alu_instr(input logic [3:0] op, input logic src2_imm,
                             input logic [31:0] rs1, input logic [31:0] rs2,
                             input logic [31:0] imm);
        idle_inputs();
        valid_in        = 1'b1;
        alu_op_in       = op;
        alu_src2_imm_in = src2_imm;
        rs1_value_in    = rs1;
        rs2_value_in    = rs2;
        imm_value_in    = imm;
        rd_in           = 5'd4;
        rd_writeback_in = 1'b1;
    endtask

    task automatic alu_check(input string tag, input logic [3:0] op, input logic src2_imm,
                             input logic [31:0] rs1, input logic [31:0] rs2,
                             input logic [31:0] imm, input logic [31:0] exp);
        alu_instr(op, src2_imm, rs1, rs2, imm);
        step();
        check(tag, result_out, exp);
        $display("txn %s rs1=%h op2=%h result=%h", tag, rs1, src2_imm ? imm : rs2, result_out);
    endtask

    task automatic run_md(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        int   n;
        logic wb_seen;
        idle_inputs();
        valid_in        = 1'b1;
        muldiv_en_in    = 1'b1;
        muldiv_op_in    = op;
        rs1_value_in    = a;
        rs2_value_in    = b;
        rd_in           = 5'd7;
        rd_writeback_in = 1'b1;
        #1;
        n       = 0;
        wb_seen = 1'b0;
        while (stall_out === 1'b1 && n < 40) begin
            n++;
            step();
            wb_seen = wb_seen | rd_writeback_out;
        end
        check({tag, " stall cycles"}, 32'(n), 32'd33);
        check({tag, " bubble during stall"}, 32'(wb_seen), 32'd0);
        step();
        check({tag, " result"}, result_out, exp);
        check({tag, " writeback"}, 32'(rd_writeback_out), 32'd1);
        check({tag, " rd"}, 32'(rd_out), 32'd7);
        $display("txn %s a=%h b=%h result=%h stall=%0d", tag, a, b, result_out, n);
        valid_in = 1'b0;
        step();
        check({tag, " writeback one cycle"}, 32'(rd_writeback_out), 32'd0);
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        repeat (2) step();
        check("reset result", result_out, 32'd0);
        check("reset branch_op", 32'(branch_op_out), 32'd0);
        check("reset writeback", 32'(rd_writeback_out), 32'd0);
        check("reset stall", 32'(stall_out), 32'd0);
        reset = 1'b0;
        step();

        // ADD with every control field passing through
        alu_instr(RV32_ALU_OP_ADD, 1'b0, 32'd5, 32'hFFFF_FFFD, 32'd0);
        read_en_in     = 1'b1;
        width_in       = 2'd2;
        zero_extend_in = 1'b1;
        branch_op_in   = 2'd2;
        rd_in          = 5'd3;
        #1;
        check("add stall", 32'(stall_out), 32'd0);
        step();
        check("add result", result_out, 32'd2);
        check("add read_en", 32'(read_en_out), 32'd1);
        check("add width", 32'(width_out), 32'd2);
        check("add zero_extend", 32'(zero_extend_out), 32'd1);
        check("add branch_op", 32'(branch_op_out), 32'd2);
        check("add rd", 32'(rd_out), 32'd3);
        check("add writeback", 32'(rd_writeback_out), 32'd1);
        $display("txn ADD result=%h", result_out);

        // Byte store: address = rs1 + imm, data = rs2
        alu_instr(RV32_ALU_OP_ADD, 1'b1, 32'h100, 32'hAB, 32'd3);
        write_en_in     = 1'b1;
        width_in        = 2'd0;
        rd_writeback_in = 1'b0;
        step();
        check("store addr", result_out, 32'h103);
        check("store data", rs2_value_out, 32'hAB);
        check("store write_en", 32'(write_en_out), 32'd1);
        check("store width", 32'(width_out), 32'd0);
        check("store writeback", 32'(rd_writeback_out), 32'd0);
        $display("txn STORE addr=%h data=%h", result_out, rs2_value_out);

        alu_check("sub",   RV32_ALU_OP_SUB,   1'b0, 32'd3, 32'd5, 32'd0, 32'hFFFF_FFFE);
        alu_check("slt",   RV32_ALU_OP_SLT,   1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1);
        alu_check("sltu",  RV32_ALU_OP_SLTU,  1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
        alu_check("sra",   RV32_ALU_OP_SRA,   1'b1, 32'h8000_0000, 32'd0, 32'h24, 32'hF800_0000);
        alu_check("srl",   RV32_ALU_OP_SRL,   1'b1, 32'h8000_0000, 32'd0, 32'h24, 32'h0800_0000);
        alu_check("sll",   RV32_ALU_OP_SLL,   1'b0, 32'h0000_0003, 32'h21, 32'd0, 32'h0000_0006);
        alu_check("xor",   RV32_ALU_OP_XOR,   1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'h0FF0_0FF0);
        alu_check("lui",   RV32_ALU_OP_PASS2, 1'b1, 32'h1111_1111, 32'd0, 32'h1234_5000, 32'h1234_5000);

        // JAL-style target keeps bit 0 when jalr is low
        alu_instr(RV32_ALU_OP_ADD, 1'b0, 32'h0, 32'h0, 32'h11);
        pc_in = 32'h2000;
        step();
        check("jal target", branch_pc_out, 32'h2011);
        $display("txn JAL target=%h", branch_pc_out);

        // Bubble on valid low
        idle_inputs();
        read_en_in      = 1'b1;
        write_en_in     = 1'b1;
        rd_writeback_in = 1'b1;
        branch_op_in    = 2'd3;
        step();
        check("bubble write_en", 32'(write_en_out), 32'd0);
        check("bubble read_en", 32'(read_en_out), 32'd0);
        check("bubble writeback", 32'(rd_writeback_out), 32'd0);
        check("bubble branch_op", 32'(branch_op_out), 32'd0);
        $display("txn BUBBLE");

        run_md("mul",       RV32_MULDIV_OP_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_md("divu0",     RV32_MULDIV_OP_DIVU,   32'd10,       32'd0,         32'hFFFF_FFFF);
        run_md("rem ovf",   RV32_MULDIV_OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run_md("div ovf",   RV32_MULDIV_OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_md("mulh",      RV32_MULDIV_OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_md("mulhsu",    RV32_MULDIV_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_md("mulhu",     RV32_MULDIV_OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_md("div neg",   RV32_MULDIV_OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
        run_md("rem neg",   RV32_MULDIV_OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
        run_md("div0 sgn",  RV32_MULDIV_OP_DIV,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF);
        run_md("rem0 sgn",  RV32_MULDIV_OP_REM,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB);
        run_md("remu",      RV32_MULDIV_OP_REMU,   32'd100,      32'd7,         32'd2);

        // Flush in iteration 10 of a divide, then an ADD the next cycle
        idle_inputs();
        valid_in        = 1'b1;
        muldiv_en_in    = 1'b1;
        muldiv_op_in    = RV32_MULDIV_OP_DIVU;
        rs1_value_in    = 32'd100;
        rs2_value_in    = 32'd7;
        rd_in           = 5'd8;
        rd_writeback_in = 1'b1;
        repeat (11) step();
        check("flush stall before", 32'(stall_out), 32'd1);
        flush_in = 1'b1;
        #1;
        check("flush stall drop", 32'(stall_out), 32'd0);
        step();
        check("flush bubble writeback", 32'(rd_writeback_out), 32'd0);
        alu_instr(RV32_ALU_OP_ADD, 1'b0, 32'd1, 32'd2, 32'd0);
        rd_in = 5'd9;
        #1;
        check("post flush stall", 32'(stall_out), 32'd0);
        step();
        check("post flush add", result_out, 32'd3);
        check("post flush writeback", 32'(rd_writeback_out), 32'd1);
        check("post flush rd", 32'(rd_out), 32'd9);
        $display("txn FLUSH then ADD result=%h", result_out);

        // Asynchronous reset in the middle of a multiply
        idle_inputs();
        valid_in        = 1'b1;
        muldiv_en_in    = 1'b1;
        muldiv_op_in    = RV32_MULDIV_OP_MUL;
        rs1_value_in    = 32'd7;
        rs2_value_in    = 32'd3;
        rd_writeback_in = 1'b1;
        repeat (5) step();
        check("pre reset stall", 32'(stall_out), 32'd1);
        check("pre reset rs2 out", rs2_value_out, 32'd3);
        #2;
        reset = 1'b1;
        idle_inputs();
        #1;
        check("async reset result", result_out, 32'd0);
        check("async reset rs2", rs2_value_out, 32'd0);
        check("async reset stall", 32'(stall_out), 32'd0);
        step();
        reset = 1'b0;

        // JALR after reset: target bit 0 cleared, accepted without stall
        alu_instr(RV32_ALU_OP_ADD, 1'b0, 32'h1001, 32'd0, 32'd4);
        jalr_in      = 1'b1;
        pc_in        = 32'h3000;
        muldiv_en_in = 1'b0;
        #1;
        check("jalr stall", 32'(stall_out), 32'd0);
        step();
        check("jalr target", branch_pc_out, 32'h1004);
        check("jalr writeback", 32'(rd_writeback_out), 32'd1);
        $display("txn JALR target=%h", branch_pc_out);

        idle_inputs();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
